// File: rtl/multi_adder_tree_pkg.sv
// Shared helpers for the pipelined signed adder tree: tree depth, internal
// width, pipeline latency and the node count of each tree level.
package multi_adder_tree_pkg;

  // Ceiling log2. Returns 0 for a value of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  // Number of adder levels needed to reduce cl_in features to one sum.
  function automatic int unsigned tree_levels(input int unsigned cl_in);
    return clog2(cl_in);
  endfunction

  // Full-precision width: one extra bit per level so the sum never overflows.
  function automatic int unsigned tree_width(input int unsigned n, input int unsigned cl_in);
    return n + clog2(cl_in);
  endfunction

  // One register per tree level plus the output register.
  function automatic int unsigned pipe_latency(input int unsigned cl_in);
    return clog2(cl_in) + 1;
  endfunction

  // Operands entering tree level 'level'. An odd node passes through with a
  // zero partner, which is equivalent to padding the leaves up to 2^L.
  function automatic int unsigned level_nodes(input int unsigned cl_in, input int unsigned level);
    int unsigned nodes;
    nodes = cl_in;
    for (int unsigned i = 0; i < level; i++) begin
      nodes = (nodes + 1) / 2;
    end
    return nodes;
  endfunction

endpackage

// File: rtl/multi_adder_tree_if.sv
// Data bus of the adder tree: packed input features with their valid flag,
// and the saturated result with its delayed valid flag.
interface multi_adder_tree_if #(
  parameter int unsigned CL_IN = 8,
  parameter int unsigned N     = 4
);
  logic [CL_IN*N-1:0] d_in;
  logic               en_in;
  logic [N-1:0]       d_out;
  logic               en_out;

  // Producer/consumer side (testbench or upstream multiplier array).
  modport master (
    output d_in,
    output en_in,
    input  d_out,
    input  en_out
  );

  // The adder tree itself.
  modport slave (
    input  d_in,
    input  en_in,
    output d_out,
    output en_out
  );
endinterface

// File: rtl/multi_adder_stage.sv
// One registered level of the adder tree: P signed W-bit operands are summed
// pairwise into ceil(P/2) registered results. An unpaired last operand is
// registered unchanged.
module multi_adder_stage #(
  parameter int unsigned P = 2,
  parameter int unsigned W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [P*W-1:0]             d_in,
  output logic [((P+1)/2)*W-1:0]     d_out
);

  localparam int unsigned Q = (P + 1) / 2;

  logic [Q*W-1:0] sum_d;
  logic [Q*W-1:0] sum_q;

  // Pairwise sums; W already carries the growth bit so wrap-free two's
  // complement addition is exact.
  always_comb begin
    sum_d = '0;
    for (int unsigned j = 0; j < Q; j++) begin
      if (2 * j + 1 < P) begin
        sum_d[j*W +: W] = d_in[2*j*W +: W] + d_in[(2*j+1)*W +: W];
      end else begin
        sum_d[j*W +: W] = d_in[2*j*W +: W];
      end
    end
  end

  // Stage register: loads every cycle, no stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign d_out = sum_q;

endmodule

// File: rtl/multi_adder_tree.sv
// Pipelined signed adder tree for one CNN output channel: sums CL_IN packed
// N-bit features at full precision, arithmetic-shifts right by SR, optionally
// clamps negatives to zero, and saturates to N bits. The valid flag follows
// the data through a matched delay line. The bus interface instance must be
// parameterised with the same CL_IN and N as this module.
module multi_adder_tree
  import multi_adder_tree_pkg::*;
#(
  parameter int unsigned CL_IN = 8,
  parameter int unsigned RELU  = 0,
  parameter int unsigned N     = 4,
  parameter int unsigned SR    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_adder_tree_if.slave    bus
);

  localparam int unsigned L   = tree_levels(CL_IN);
  localparam int unsigned W   = tree_width(N, CL_IN);
  localparam int unsigned LAT = pipe_latency(CL_IN);

  localparam logic signed [W-1:0] SAT_MAX = W'((1 << (N - 1)) - 1);
  localparam logic signed [W-1:0] SAT_MIN = ~SAT_MAX;

  logic [CL_IN*W-1:0]  leaves;
  logic signed [W-1:0] sum_s;
  logic signed [W-1:0] shifted;
  logic [N-1:0]        d_out_d;
  logic [N-1:0]        d_out_q;
  logic [LAT-1:0]      en_pipe_d;
  logic [LAT-1:0]      en_pipe_q;

  // Sign-extend every feature to the full-precision tree width.
  always_comb begin
    leaves = '0;
    for (int unsigned i = 0; i < CL_IN; i++) begin
      leaves[i*W +: W] = W'($signed(bus.d_in[i*N +: N]));
    end
  end

  // Tree levels: level k consumes the registered outputs of level k-1.
  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int unsigned P = level_nodes(CL_IN, k);
    localparam int unsigned Q = level_nodes(CL_IN, k + 1);

    logic [P*W-1:0] stage_in;
    logic [Q*W-1:0] stage_out;

    if (k == 0) begin : g_first
      assign stage_in = leaves[P*W-1:0];
    end else begin : g_next
      assign stage_in = g_lvl[k-1].stage_out;
    end

    multi_adder_stage #(
      .P (P),
      .W (W)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst),
      .d_in  (stage_in),
      .d_out (stage_out)
    );
  end

  // A single feature needs no tree; it goes straight to post-processing.
  if (L == 0) begin : g_flat
    assign sum_s = leaves[W-1:0];
  end else begin : g_tree
    assign sum_s = g_lvl[L-1].stage_out;
  end

  // Shift (floor toward -inf), optional ReLU, then saturate to N bits.
  always_comb begin
    shifted = sum_s >>> SR;
    d_out_d = '0;
    if (RELU != 0 && shifted[W-1]) begin
      d_out_d = '0;
    end else if (shifted > SAT_MAX) begin
      d_out_d = SAT_MAX[N-1:0];
    end else if (shifted < SAT_MIN) begin
      d_out_d = SAT_MIN[N-1:0];
    end else begin
      d_out_d = shifted[N-1:0];
    end
  end

  // Valid delay line, one bit per register stage of the data path.
  always_comb begin
    en_pipe_d = LAT'({en_pipe_q, bus.en_in});
  end

  // Output register and valid delay line; both cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out_q   <= '0;
      en_pipe_q <= '0;
    end else begin
      d_out_q   <= d_out_d;
      en_pipe_q <= en_pipe_d;
    end
  end

  assign bus.d_out  = d_out_q;
  assign bus.en_out = en_pipe_q[LAT-1];

endmodule

// File: tb/tb_multi_adder_tree.sv
// Scoreboard bench for multi_adder_tree. Three instances share clock and
// reset: A (CL_IN=8, RELU=0, SR=1), R (CL_IN=8, RELU=1, SR=1) fed the same
// vectors as A, and C (CL_IN=3, SR=0). Stimulus pushes expected results with
// their due cycle; a negedge monitor pops and compares whenever en_out is high.
module tb_multi_adder_tree;

  typedef struct {
    logic [3:0]  val;
    int unsigned due;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  ea;
    logic [3:0]  er;
  } vec_ab_t;

  typedef struct {
    logic [11:0] d;
    logic [3:0]  ec;
  } vec_c_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  exp_t  sb [3][$];
  string names [3] = '{"A", "R", "C"};

  // Hand-computed results: A = sat(sum>>>1), R additionally clamps negatives.
  vec_ab_t tab_ab [10] = '{
    '{32'h11111111, 4'h4, 4'h4},   //  8 >>> 1 =  4
    '{32'hFFFFFFFF, 4'hC, 4'h0},   // -8 >>> 1 = -4
    '{32'h77777777, 4'h7, 4'h7},   // 56 >>> 1 = 28 -> +7
    '{32'h88888888, 4'h8, 4'h0},   // -64 >>> 1 = -32 -> -8
    '{32'h0000000F, 4'hF, 4'h0},   // -1 >>> 1 = -1 (floor)
    '{32'h00000003, 4'h1, 4'h1},   //  3 >>> 1 =  1
    '{32'h00000001, 4'h0, 4'h0},   //  1 >>> 1 =  0
    '{32'hF0000001, 4'h0, 4'h0},   // -1 + 1 = 0
    '{32'h7777777F, 4'h7, 4'h7},   // 48 >>> 1 = 24 -> +7
    '{32'h000000FE, 4'hE, 4'h0}    // -3 >>> 1 = -2
  };

  // CL_IN=3, SR=0: d_out = sat(f0+f1+f2).
  vec_c_t tab_c [5] = '{
    '{12'h321, 4'h6},   //  1+2+3 =  6
    '{12'hFED, 4'hA},   // -3-2-1 = -6
    '{12'h777, 4'h7},   //  21 -> +7
    '{12'h888, 4'h8},   // -24 -> -8
    '{12'h00F, 4'hF}    // -1
  };

  multi_adder_tree_if #(.CL_IN(8), .N(4)) if_a ();
  multi_adder_tree_if #(.CL_IN(8), .N(4)) if_r ();
  multi_adder_tree_if #(.CL_IN(3), .N(4)) if_c ();

  multi_adder_tree #(.CL_IN(8), .RELU(0), .N(4), .SR(1)) dut_a (.clk(clk), .rst(rst_n), .bus(if_a));
  multi_adder_tree #(.CL_IN(8), .RELU(1), .N(4), .SR(1)) dut_r (.clk(clk), .rst(rst_n), .bus(if_r));
  multi_adder_tree #(.CL_IN(3), .RELU(0), .N(4), .SR(0)) dut_c (.clk(clk), .rst(rst_n), .bus(if_c));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_flag(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_int(input string name, input int unsigned act, input int unsigned req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Golden result for k 4-bit features: floor shift, optional ReLU, saturate.
  function automatic logic [3:0] model(input logic [31:0] d, input int cnt, input int sr, input bit relu);
    int s;
    s = 0;
    for (int i = 0; i < cnt; i++) s += int'($signed(d[i*4 +: 4]));
    s = s >>> sr;
    if (relu && s < 0) s = 0;
    if (s > 7) s = 7;
    if (s < -8) s = -8;
    return s[3:0];
  endfunction

  // One cycle of stimulus; expected results are queued with their due cycle.
  task automatic drive(input logic en_ab, input logic [31:0] dab, input logic [3:0] ea,
                       input logic [3:0] er, input logic en_c, input logic [11:0] dc,
                       input logic [3:0] ec);
    @(posedge clk);
    #1;
    if_a.d_in  = dab;
    if_r.d_in  = dab;
    if_a.en_in = en_ab;
    if_r.en_in = en_ab;
    if_c.d_in  = dc;
    if_c.en_in = en_c;
    if (en_ab) begin
      sb[0].push_back('{ea, cyc + 4});
      sb[1].push_back('{er, cyc + 4});
    end
    if (en_c) sb[2].push_back('{ec, cyc + 3});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic check_reset_outputs();
    check_val("A reset d_out", if_a.d_out, 4'h0);
    check_flag("A reset en_out", if_a.en_out, 1'b0);
    check_val("R reset d_out", if_r.d_out, 4'h0);
    check_flag("R reset en_out", if_r.en_out, 1'b0);
    check_val("C reset d_out", if_c.d_out, 4'h0);
    check_flag("C reset en_out", if_c.en_out, 1'b0);
  endtask

  task automatic noisy_inputs();
    if_a.d_in  = $urandom;
    if_r.d_in  = if_a.d_in;
    if_c.d_in  = 12'($urandom);
    if_a.en_in = 1'b1;
    if_r.en_in = 1'b1;
    if_c.en_in = 1'b1;
  endtask

  // Monitor: every en_out must match the oldest queued expectation, both in
  // value and in cycle; an expectation whose cycle passes without en_out fails.
  always @(negedge clk) begin : monitor
    logic       en_v [3];
    logic [3:0] d_v  [3];
    exp_t       e;
    en_v[0] = if_a.en_out;  d_v[0] = if_a.d_out;
    en_v[1] = if_r.en_out;  d_v[1] = if_r.d_out;
    en_v[2] = if_c.en_out;  d_v[2] = if_c.d_out;
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (en_v[k]) begin
          if (sb[k].size() == 0) begin
            check_flag({names[k], " spurious en_out"}, en_v[k], 1'b0);
          end else begin
            e = sb[k].pop_front();
            check_val({names[k], " d_out"}, d_v[k], e.val);
            check_int({names[k], " output cycle"}, cyc, e.due);
          end
        end else if (sb[k].size() != 0 && sb[k][0].due <= cyc) begin
          e = sb[k].pop_front();
          check_flag({names[k], " missing en_out"}, en_v[k], 1'b1);
        end
      end
    end
  end

  initial begin
    logic [31:0] dab;
    logic [11:0] dc;

    // Reset held with live-looking inputs: outputs must stay cleared.
    noisy_inputs();
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    if_a.en_in = 1'b0;
    if_r.en_in = 1'b0;
    if_c.en_in = 1'b0;
    idle(3);

    // Isolated pulses first (single-cycle en_out), then back-to-back vectors.
    foreach (tab_ab[i]) begin
      drive(1'b1, tab_ab[i].d, tab_ab[i].ea, tab_ab[i].er, 1'b0, '0, '0);
      if (i < 4) idle(5);
    end
    idle(6);

    // Odd-width tree.
    foreach (tab_c[i]) begin
      drive(1'b0, '0, '0, '0, 1'b1, tab_c[i].d, tab_c[i].ec);
      if (i < 2) idle(4);
    end
    idle(6);

    // Continuous stream on all instances.
    for (int v = 1; v <= 100; v++) begin
      for (int i = 0; i < 8; i++) dab[i*4 +: 4] = 4'((v + i) % 16);
      for (int i = 0; i < 3; i++) dc[i*4 +: 4]  = 4'((v + i) % 16);
      drive(1'b1, dab, model(dab, 8, 1, 1'b0), model(dab, 8, 1, 1'b1),
            1'b1, dc, model({20'h0, dc}, 3, 0, 1'b0));
    end
    idle(6);

    // Mid-stream asynchronous reset: in-flight vectors are discarded.
    for (int i = 0; i < 6; i++) drive(1'b1, 32'h11111111, 4'h4, 4'h4, 1'b1, 12'h321, 4'h6);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    noisy_inputs();
    for (int k = 0; k < 3; k++) sb[k].delete();
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    if_a.en_in = 1'b0;
    if_r.en_in = 1'b0;
    if_c.en_in = 1'b0;
    idle(6);
    drive(1'b1, 32'h11111111, 4'h4, 4'h4, 1'b1, 12'h321, 4'h6);
    idle(6);

    // Bounded drain of anything still outstanding.
    for (int i = 0; i < 20 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0; i++) begin
      @(posedge clk);
    end
    for (int k = 0; k < 3; k++) check_int({names[k], " outstanding results"}, sb[k].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
